// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and helpers for the I2S serializer.
// Channel encodings on lrclk, frame length helper and a parameter legality
// function used by the serializer's configuration checks.
package i2s_pkg;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  // Number of bclk periods in one full left+right frame.
  function automatic int i2s_frame_bits(input int w_slot);
    return 2 * w_slot;
  endfunction

  // Legal parameter set: the slot must hold the one-bit delay plus the word,
  // and the divider needs at least two clk cycles per bclk half-period.
  function automatic bit i2s_params_ok(input int w_ser, input int w_slot,
                                       input int clk_div);
    return (w_ser >= 1) && (w_slot >= w_ser + 1) && (clk_div >= 2);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: bit-clock divider for the I2S serializer.
// div_cnt runs 0..clk_div-1; bclk toggles at the terminal count. fall_ev and
// rise_ev are combinational strobes that are high in the cycle whose closing
// clk edge takes bclk low (fall) or high (rise), so downstream registers can
// update on exactly the edge where bclk changes.
module i2s_clk_gen #(
  parameter int clk_div = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall_ev,
  output logic rise_ev
);

  localparam int DW = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(clk_div - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          term;

  // Next divider count, bclk toggle and edge strobes.
  always_comb begin
    term      = (div_cnt_q == DIV_LAST);
    div_cnt_d = term ? '0 : div_cnt_q + 1'b1;
    bclk_d    = term ? ~bclk_q : bclk_q;
    fall_ev   = term && bclk_q;
    rise_ev   = term && !bclk_q;
  end

  // Divider state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk = bclk_q;

endmodule

// File: rtl/i2s_ser.sv
// i2s_ser: Philips I2S transmitter and bit-clock master.
// A one-entry holding buffer accepts {left,right} pairs; at each frame start
// the buffer moves into the frame register, which the output mux serializes
// MSB first with a one-bclk delay after every lrclk change.
// Build option I2S_SER_HOLD_EN: when defined, an underrun keeps the previous
// frame register contents (last frame repeats); when undefined, an underrun
// loads zeros (silence). The underrun pulse is produced in both builds.
//
// Handshake: a pair transfers on any clk edge where in_valid && in_ready.
// in_ready is the registered inverse of the buffer-full flag, so it depends
// only on state, never on in_valid. The producer must hold in_left/in_right
// stable while in_valid is high and in_ready is low.
module i2s_ser
  import i2s_pkg::*;
#(
  parameter int w_ser   = 24,
  parameter int w_slot  = 32,
  parameter int clk_div = 4,
  parameter bit stereo  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [w_ser-1:0] in_left,
  input  logic [w_ser-1:0] in_right,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sd,
  output logic             underrun
);

  localparam int FRAME_BITS = i2s_frame_bits(w_slot);
  localparam int BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_W   = BW'(w_slot);
  localparam bit PARAMS_OK = i2s_params_ok(w_ser, w_slot, clk_div);

  logic fall_ev, rise_ev;

  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             buf_full_q, buf_full_d;
  logic [w_ser-1:0] buf_l_q, buf_l_d;
  logic [w_ser-1:0] buf_r_q, buf_r_d;
  logic [w_ser-1:0] frame_l_q, frame_l_d;
  logic [w_ser-1:0] frame_r_q, frame_r_d;
  logic             lrclk_q, lrclk_d;
  logic             sd_q, sd_d;
  logic             underrun_q, underrun_d;

  logic             hs;
  logic             frame_start;
  logic             chan;
  logic [BW-1:0]    slot_pos;
  logic [w_ser-1:0] word;

  i2s_clk_gen #(
    .clk_div (clk_div)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .bclk    (bclk),
    .fall_ev (fall_ev),
    .rise_ev (rise_ev)
  );

  // Bit counter, holding buffer and frame register update.
  always_comb begin
    hs          = in_valid && !buf_full_q;
    frame_start = fall_ev && (bit_cnt_q == BIT_LAST);

    bit_cnt_d  = bit_cnt_q;
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    frame_l_d  = frame_l_q;
    frame_r_d  = frame_r_q;
    underrun_d = 1'b0;

    if (fall_ev) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end

    if (frame_start) begin
      if (buf_full_q) begin
        frame_l_d  = buf_l_q;
        frame_r_d  = stereo ? buf_r_q : '0;
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
`ifdef I2S_SER_HOLD_EN
        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
`else
        frame_l_d = '0;
        frame_r_d = '0;
`endif
      end
    end

    // A pair accepted on an underrunning frame start waits for the next frame.
    if (hs) begin
      buf_full_d = 1'b1;
      buf_l_d    = in_left;
      buf_r_d    = in_right;
    end
  end

  // Output mux: lrclk and sd follow the new bit position on fall events only.
  always_comb begin
    chan     = (bit_cnt_d >= SLOT_W) ? I2S_RIGHT : I2S_LEFT;
    slot_pos = (chan == I2S_RIGHT) ? bit_cnt_d - SLOT_W : bit_cnt_d;
    word     = (chan == I2S_RIGHT) ? frame_r_d : frame_l_d;
    lrclk_d  = lrclk_q;
    sd_d     = sd_q;
    if (fall_ev) begin
      lrclk_d = chan;
      sd_d    = 1'b0;
      for (int i = 0; i < w_ser; i++) begin
        if (slot_pos == BW'(w_ser - i)) sd_d = word[i];
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q  <= BIT_LAST;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      frame_l_q  <= '0;
      frame_r_q  <= '0;
      lrclk_q    <= I2S_RIGHT;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      frame_l_q  <= frame_l_d;
      frame_r_q  <= frame_r_d;
      lrclk_q    <= lrclk_d;
      sd_q       <= sd_d;
      underrun_q <= underrun_d;
    end
  end

  // Configuration legality and sd stability across bclk rising edges.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (PARAMS_OK) else $error("i2s_ser: illegal parameter set");
      if (rise_ev) begin
        assert (sd_d == sd_q) else $error("i2s_ser: sd changed on a bclk rise");
      end
    end
  end

  assign in_ready = !buf_full_q;
  assign lrclk    = lrclk_q;
  assign sd       = sd_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_ser.sv
// tb_i2s_ser: directed bench for i2s_ser (defaults, stereo and mono copies).
// A negedge monitor deserializes frames at bclk rises and timestamps lrclk
// falls, underrun pulses and in_ready rises; the main sequence drives pairs
// and compares everything against hand-derived expectations.
module tb_i2s_ser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] in_left = '0;
  logic [23:0] in_right = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, bclk, lrclk, sd, underrun;
  logic        m_in_ready, m_bclk, m_lrclk, m_sd, m_underrun;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_ser #(.w_ser(24), .w_slot(32), .clk_div(4), .stereo(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk),
    .sd(sd), .underrun(underrun)
  );

  i2s_ser #(.w_ser(24), .w_slot(32), .clk_div(4), .stereo(1'b0)) dut_mono (
    .clk(clk), .rst_n(rst_n), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(m_in_ready), .bclk(m_bclk), .lrclk(m_lrclk),
    .sd(m_sd), .underrun(m_underrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 8'h00, r, 7'h00};
  endfunction

  // ---------------- monitor ----------------
  logic        prev_bclk = 1'b0, prev_lr = 1'b1, prev_rdy = 1'b1, rise_lr = 1'b1;
  logic [63:0] sh = '0, shm = '0;
  int          nbits = 0;
  logic [63:0] frames_q[$];
  logic [63:0] mono_q[$];
  int          lr_fall_q[$];
  int          bclk_rise_q[$];
  int          under_q[$];
  int          rdy_rise_q[$];
  int          rdy_hi_cnt = 0;
  int          win_lo = 0, win_hi = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits   = 0;
      rise_lr = 1'b1;
    end else begin
      if (lrclk !== prev_lr) begin
        if (lrclk == 1'b0) lr_fall_q.push_back(cyc);
        check("lr_edge_on_bclk_fall", {62'b0, prev_bclk, bclk}, 64'h2);
      end
      if (bclk && !prev_bclk) begin
        if (bclk_rise_q.size() < 4) bclk_rise_q.push_back(cyc);
        if (!lrclk && rise_lr) begin
          sh    = 64'(sd);
          shm   = 64'(m_sd);
          nbits = 1;
        end else if (nbits > 0) begin
          sh    = {sh[62:0], sd};
          shm   = {shm[62:0], m_sd};
          nbits = nbits + 1;
        end
        if (nbits == 64) begin
          frames_q.push_back(sh);
          mono_q.push_back(shm);
          nbits = 0;
        end
        rise_lr = lrclk;
      end
      if (underrun) under_q.push_back(cyc);
      if (in_ready && !prev_rdy) rdy_rise_q.push_back(cyc);
      if (in_ready && cyc >= win_lo && cyc <= win_hi) rdy_hi_cnt++;
    end
    prev_bclk = bclk;
    prev_lr   = lrclk;
    prev_rdy  = in_ready;
  end

  // Offer a pair with in_valid held high; returns on the negedge after the
  // edge that accepts it.
  task automatic offer(input logic [23:0] l, input logic [23:0] r, input string tag);
    int guard;
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 700) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_wait_bound"}, 64'(guard < 700), 64'h1);
    @(negedge clk);
    check({tag, "_ready_fall"}, 64'(in_ready), 64'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rel;
    int rel2;
    logic [63:0] exp_f[7];
    logic [23:0] hold_l, hold_r;

    // Reset state
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_bclk", 64'(bclk), 64'h0);
    check("rst_lrclk", 64'(lrclk), 64'h1);
    check("rst_sd", 64'(sd), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_underrun", 64'(underrun), 64'h0);

    rst_n  = 1'b1;
    rel    = cyc;
    win_lo = rel + 1000;
    win_hi = rel + 2100;

    // First frame start: 8 clk after release, empty buffer -> underrun
    repeat (7) @(negedge clk);
    check("pre_fs_lrclk", 64'(lrclk), 64'h1);
    check("pre_fs_underrun", 64'(underrun), 64'h0);
    @(negedge clk);
    check("fs1_bclk", 64'(bclk), 64'h0);
    check("fs1_lrclk", 64'(lrclk), 64'h0);
    check("fs1_underrun", 64'(underrun), 64'h1);
    check("fs1_mono_underrun", 64'(m_underrun), 64'h1);

    // Push first pair right after frame 1 starts
    in_left  = 24'hA5A5A5;
    in_right = 24'h123456;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("push1_ready_fall", 64'(in_ready), 64'h0);
    check("push1_mono_ready_fall", 64'(m_in_ready), 64'h0);
    check("underrun_one_cycle", 64'(underrun), 64'h0);

    // Back-to-back feed with in_valid held high, samples 1,2,3 then 0x7FFFFF
    repeat (591) @(negedge clk);
    offer(24'h000001, 24'h800001, "s1");
    offer(24'h000002, 24'h555555, "s2");
    offer(24'h000003, 24'hFFFFFF, "s3");
    offer(24'h7FFFFF, 24'h000001, "s4");
    in_valid = 1'b0;

    // Frame 7 (underrun) completes its last rise at rel+3588
    while (cyc < rel + 3590) @(negedge clk);

    exp_f[0] = frame_of(24'h000000, 24'h000000);
    exp_f[1] = frame_of(24'hA5A5A5, 24'h123456);
    exp_f[2] = frame_of(24'h000001, 24'h800001);
    exp_f[3] = frame_of(24'h000002, 24'h555555);
    exp_f[4] = frame_of(24'h000003, 24'hFFFFFF);
    exp_f[5] = frame_of(24'h7FFFFF, 24'h000001);
`ifdef I2S_SER_HOLD_EN
    hold_l = 24'h7FFFFF;
    hold_r = 24'h000001;
`else
    hold_l = 24'h000000;
    hold_r = 24'h000000;
`endif
    exp_f[6] = frame_of(hold_l, hold_r);

    check("frame_count", 64'(frames_q.size()), 64'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < frames_q.size()) check($sformatf("frame%0d", k + 1), frames_q[k], exp_f[k]);
    end
    if (mono_q.size() >= 6) begin
      check("mono_frame2", mono_q[1], frame_of(24'hA5A5A5, 24'h000000));
      check("mono_frame5", mono_q[4], frame_of(24'h000003, 24'h000000));
      check("mono_frame6", mono_q[5], frame_of(24'h7FFFFF, 24'h000000));
    end else begin
      check("mono_frame_count", 64'(mono_q.size()), 64'd7);
    end

    // Clock geometry
    check("bclk_rise_count", 64'(bclk_rise_q.size()), 64'd4);
    if (bclk_rise_q.size() >= 2) begin
      check("bclk_first_rise", 64'(bclk_rise_q[0]), 64'(rel + 4));
      check("bclk_period", 64'(bclk_rise_q[1] - bclk_rise_q[0]), 64'd8);
    end
    check("lr_fall_count", 64'(lr_fall_q.size()), 64'd7);
    if (lr_fall_q.size() >= 3) begin
      check("lr_fall_first", 64'(lr_fall_q[0]), 64'(rel + 8));
      check("lrclk_period", 64'(lr_fall_q[1] - lr_fall_q[0]), 64'd512);
      check("lr_fall_third", 64'(lr_fall_q[2]), 64'(rel + 1032));
    end

    // Underrun only on frame 1 and frame 7
    check("underrun_count", 64'(under_q.size()), 64'd2);
    if (under_q.size() >= 2) begin
      check("underrun_frame1", 64'(under_q[0]), 64'(rel + 8));
      check("underrun_frame7", 64'(under_q[1]), 64'(rel + 3080));
    end

    // in_ready rises once per drained frame and pulses one cycle while fed
    check("ready_rise_count", 64'(rdy_rise_q.size()), 64'd5);
    if (rdy_rise_q.size() >= 5) begin
      check("ready_rise_f2", 64'(rdy_rise_q[0]), 64'(rel + 520));
      check("ready_rise_f3", 64'(rdy_rise_q[1]), 64'(rel + 1032));
      check("ready_rise_f4", 64'(rdy_rise_q[2]), 64'(rel + 1544));
      check("ready_rise_f6", 64'(rdy_rise_q[4]), 64'(rel + 2568));
    end
    check("ready_pulse_cycles", 64'(rdy_hi_cnt), 64'd3);

    // Fill the buffer, then reset during bit 10 of frame 8's left slot
    while (cyc < rel + 3600) @(negedge clk);
    in_left  = 24'h654321;
    in_right = 24'h0FEDCB;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < rel + 3677) @(negedge clk);
    check("pre_rst_bclk", 64'(bclk), 64'h1);
    check("pre_rst_lrclk", 64'(lrclk), 64'h0);
    check("pre_rst_in_ready", 64'(in_ready), 64'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bclk", 64'(bclk), 64'h0);
    check("midrst_lrclk", 64'(lrclk), 64'h1);
    check("midrst_sd", 64'(sd), 64'h0);
    check("midrst_in_ready", 64'(in_ready), 64'h1);
    check("midrst_underrun", 64'(underrun), 64'h0);
    repeat (2) @(negedge clk);
    frames_q.delete();
    mono_q.delete();
    lr_fall_q.delete();
    under_q.delete();
    rst_n = 1'b1;
    rel2  = cyc;

    repeat (7) @(negedge clk);
    check("rel2_pre_fall_lrclk", 64'(lrclk), 64'h1);
    check("rel2_pre_fall_bclk", 64'(bclk), 64'h1);
    @(negedge clk);
    check("rel2_fall_bclk", 64'(bclk), 64'h0);
    check("rel2_fall_lrclk", 64'(lrclk), 64'h0);
    check("rel2_underrun", 64'(underrun), 64'h1);
    check("rel2_buffer_dropped", 64'(in_ready), 64'h1);
    repeat (12) @(negedge clk);
    check("rel2_lr_fall_count", 64'(lr_fall_q.size()), 64'd1);
    if (lr_fall_q.size() >= 1) check("rel2_lr_fall_time", 64'(lr_fall_q[0]), 64'(rel2 + 8));
    check("rel2_underrun_count", 64'(under_q.size()), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
